// File: rtl/gsim_solver_param.sv
// Gauss-Seidel solver for the fixed symmetric 7-diagonal system A*x = b.
// It loads N b values, sweeps in place on fixed-point x, then streams x out under backpressure.
module gsim_solver_param #(
  parameter int N      = 16,
  parameter int B_W    = 16,
  parameter int X_W    = 32,
  parameter int FRAC   = 16,
  parameter int ITER_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [B_W-1:0]    b_in,
  input  logic [ITER_W-1:0]        iter_limit,
  input  logic [X_W-1:0]           tol,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [X_W-1:0]    x_out,
  output logic                     out_last,
  output logic [ITER_W-1:0]        out_iters,
  output logic                     converged
);

  // Handshake: a word moves only on a clock edge where valid && ready are both high;
  // a producer holding valid keeps its data stable until that edge.

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int PAD_W = $clog2(N + 6);
  localparam int NUM_W = ((X_W > B_W + FRAC) ? X_W : B_W + FRAC) + 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  localparam logic signed [NUM_W-1:0] C6     = NUM_W'(6);
  localparam logic signed [NUM_W-1:0] C13    = NUM_W'(13);
  localparam logic signed [NUM_W-1:0] C20    = NUM_W'(20);
  localparam logic signed [NUM_W-1:0] ONE_N  = NUM_W'(1);
  localparam logic signed [NUM_W-1:0] XMAX_N = {{(NUM_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [NUM_W-1:0] XMIN_N = {{(NUM_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};
  localparam logic signed [X_W-1:0]   XMAX   = {1'b0, {(X_W-1){1'b1}}};
  localparam logic signed [X_W-1:0]   XMIN   = {1'b1, {(X_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD, SOLVE, DRAIN} state_t;

  state_t                  state;
  logic signed [X_W-1:0]   x_mem [N];
  logic signed [B_W-1:0]   b_mem [N];
  logic [IDX_W-1:0]        idx;
  logic [ITER_W-1:0]       sweep_cnt;
  logic [ITER_W-1:0]       limit;
  logic [X_W-1:0]          tol_q;
  logic [X_W-1:0]          max_delta;

  logic signed [NUM_W-1:0] xp [N+6];
  logic [PAD_W-1:0]        rpk [7];
  logic signed [NUM_W-1:0] num;
  logic signed [NUM_W-1:0] quo;
  logic signed [NUM_W-1:0] rem;
  logic signed [X_W-1:0]   x_new;
  logic signed [X_W:0]     diff;
  logic signed [X_W:0]     neg_diff;
  logic [X_W-1:0]          delta;
  logic [X_W-1:0]          md_next;
  logic [IDX_W-1:0]        idx_nx;
  logic [ITER_W-1:0]       sweep_nx;
  logic                    tol_met;

  // Row update: x is zero-padded by 3 on each side so out-of-range neighbours read as 0.
  always_comb begin
    for (int k = 0; k < N + 6; k++) xp[k] = '0;
    for (int k = 0; k < N; k++) xp[k+3] = {{(NUM_W-X_W){x_mem[k][X_W-1]}}, x_mem[k]};
    for (int k = 0; k < 7; k++) rpk[k] = PAD_W'(idx) + PAD_W'(k);
    num = ({{(NUM_W-B_W){b_mem[idx][B_W-1]}}, b_mem[idx]} <<< FRAC)
        + C13 * (xp[rpk[2]] + xp[rpk[4]])
        - C6  * (xp[rpk[1]] + xp[rpk[5]])
        + xp[rpk[0]] + xp[rpk[6]];
    quo = num / C20;
    rem = num % C20;
    // Division truncates toward zero; step down once for negative inexact results.
    if (rem != '0 && num[NUM_W-1]) quo = quo - ONE_N;
    if (quo > XMAX_N)      x_new = XMAX;
    else if (quo < XMIN_N) x_new = XMIN;
    else                   x_new = quo[X_W-1:0];
    diff     = {x_new[X_W-1], x_new} - {x_mem[idx][X_W-1], x_mem[idx]};
    neg_diff = -diff;
    delta    = diff[X_W] ? neg_diff[X_W-1:0] : diff[X_W-1:0];
    md_next  = (delta > max_delta) ? delta : max_delta;
    idx_nx   = idx + IDX_W'(1);
    sweep_nx = sweep_cnt + ITER_W'(1);
    tol_met  = (md_next <= tol_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      out_last  <= 1'b0;
      out_iters <= '0;
      converged <= 1'b0;
      idx       <= '0;
      sweep_cnt <= '0;
      limit     <= '0;
      tol_q     <= '0;
      max_delta <= '0;
      for (int k = 0; k < N; k++) begin
        x_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            b_mem[idx] <= b_in;
            if (idx == '0) begin
              limit <= (iter_limit == '0) ? ITER_W'(1) : iter_limit;
              tol_q <= tol;
            end
            if (idx == LAST) begin
              in_ready  <= 1'b0;
              idx       <= '0;
              sweep_cnt <= '0;
              max_delta <= '0;
              for (int k = 0; k < N; k++) x_mem[k] <= '0;
              state     <= SOLVE;
            end else begin
              idx <= idx_nx;
            end
          end
        end
        SOLVE: begin
          x_mem[idx] <= x_new;
          if (idx == LAST) begin
            sweep_cnt <= sweep_nx;
            idx       <= '0;
            max_delta <= '0;
            // Tolerance wins over the iteration limit when both hold.
            if (tol_met || sweep_nx == limit) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              x_out     <= x_mem[0];
              out_last  <= 1'b0;
              out_iters <= sweep_nx;
              converged <= tol_met;
            end
          end else begin
            idx       <= idx_nx;
            max_delta <= md_next;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (idx == LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              idx       <= '0;
              state     <= LOAD;
            end else begin
              idx      <= idx_nx;
              x_out    <= x_mem[idx_nx];
              out_last <= (idx_nx == LAST);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_solver_param.sv
// Randomised bench for gsim_solver_param: an arithmetic Gauss-Seidel model feeds a scoreboard
// queue that a negedge monitor drains on every output handshake.
module tb_gsim_solver_param;
  localparam int N      = 16;
  localparam int B_W    = 16;
  localparam int X_W    = 32;
  localparam int FRAC   = 16;
  localparam int ITER_W = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [B_W-1:0] b_in;
  logic [ITER_W-1:0]     iter_limit;
  logic [X_W-1:0]        tol;
  logic                  out_valid;
  logic                  out_ready;
  logic [X_W-1:0]        x_out;
  logic                  out_last;
  logic [ITER_W-1:0]     out_iters;
  logic                  converged;

  logic drv_valid, noise_en, noise_bit, rdy_mode, rnd_ready, manual_ready;
  assign in_valid  = drv_valid | (noise_en & noise_bit);
  assign out_ready = rdy_mode ? rnd_ready : manual_ready;

  gsim_solver_param #(.N(N), .B_W(B_W), .X_W(X_W), .FRAC(FRAC), .ITER_W(ITER_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
    .iter_limit(iter_limit), .tol(tol), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .out_last(out_last), .out_iters(out_iters), .converged(converged)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    noise_bit = 1'($urandom_range(0, 1));
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- scoreboard ----------------
  logic [X_W-1:0]    exp_q[$];
  logic              exp_last_q[$];
  logic [ITER_W-1:0] exp_it_q[$];
  logic              exp_cv_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic signed [B_W-1:0] bvec [N];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_queues();
    exp_q.delete(); exp_last_q.delete(); exp_it_q.delete(); exp_cv_q.delete();
  endtask

  function automatic longint fdiv20(input longint v);
    if (v >= 0) return v / 20;
    return -((-v + 19) / 20);
  endfunction

  // Reference: plain Gauss-Seidel on integer arrays with the solver's stopping rules.
  task automatic push_model(input int lim, input longint tolv);
    longint x [N];
    longint coef [4];
    longint num, xn, d, md, xmax, xmin, dmax;
    int it, lim_e;
    bit cv;
    coef[0] = 0; coef[1] = 13; coef[2] = -6; coef[3] = 1;
    xmax = (longint'(1) <<< (X_W - 1)) - 1;
    xmin = -xmax - 1;
    dmax = (longint'(1) <<< X_W) - 1;
    lim_e = (lim == 0) ? 1 : lim;
    for (int i = 0; i < N; i++) x[i] = 0;
    it = 0;
    cv = 0;
    while (1'b1) begin
      md = 0;
      for (int i = 0; i < N; i++) begin
        num = longint'(bvec[i]) * (longint'(1) <<< FRAC);
        for (int k = 1; k <= 3; k++) begin
          if (i - k >= 0) num += coef[k] * x[i-k];
          if (i + k < N)  num += coef[k] * x[i+k];
        end
        xn = fdiv20(num);
        if (xn > xmax) xn = xmax;
        if (xn < xmin) xn = xmin;
        d = xn - x[i];
        if (d < 0) d = -d;
        if (d > dmax) d = dmax;
        if (d > md) md = d;
        x[i] = xn;
      end
      it++;
      if (md <= tolv) begin cv = 1; break; end
      if (it >= lim_e) break;
    end
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(x[i][X_W-1:0]);
      exp_last_q.push_back(i == N - 1);
      exp_it_q.push_back(ITER_W'(it));
      exp_cv_q.push_back(cv);
    end
  endtask

  // ---------------- monitor ----------------
  logic           prev_hold = 1'b0;
  logic [X_W-1:0] prev_x;
  logic           prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_x", x_out, prev_x);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid) check("no_overlap_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got x %0h, expected no word", x_out);
        end else begin
          check("x_out", x_out, exp_q.pop_front());
          check("out_last", out_last, exp_last_q.pop_front());
          check("out_iters", out_iters, exp_it_q.pop_front());
          check("converged", converged, exp_cv_q.pop_front());
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_x    = x_out;
      prev_last = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_iters", out_iters, 0);
    check("rst_converged", converged, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv_valid = 1'b0;
    noise_en = 1'b0;
    flush_queues();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  task automatic load_problem(input int lim, input longint tolv);
    int cyc;
    for (int k = 0; k < N; k++) begin
      drv_valid = 1'b1;
      b_in = bvec[k];
      if (k == 0) begin
        iter_limit = ITER_W'(lim);
        tol = X_W'(tolv);
      end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!in_ready && cyc < 100);
      if (!in_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_timeout: in_ready stayed 0 at word %0d, expected 1", k);
        drv_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        iter_limit = ITER_W'($urandom_range(0, 255));
        tol = X_W'($urandom());
      end
      drv_valid = 1'b0;
      b_in = B_W'($urandom());
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      do_reset();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < budget);
    noise_en = 1'b0;
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: out_valid 0 after %0d cycles, expected 1", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_words(input int count);
    for (int w = 0; w < count; w++) begin
      manual_ready = 1'b1;
      @(posedge clk); #1;
      manual_ready = 1'b0;
    end
  endtask

  task automatic run_problem(input int lim, input longint tolv);
    push_model(lim, tolv);
    load_problem(lim, tolv);
    wait_done(4 * N * ((lim == 0) ? 1 : lim) + 20 * N + 50);
  endtask

  task automatic clear_b();
    for (int i = 0; i < N; i++) bvec[i] = '0;
  endtask

  task automatic random_b();
    for (int i = 0; i < N; i++) bvec[i] = B_W'($urandom());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    drv_valid = 1'b0; noise_en = 1'b0; rdy_mode = 1'b0; manual_ready = 1'b1;
    b_in = '0; iter_limit = '0; tol = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    release_reset();

    clear_b(); bvec[0] = 16'sd20;  run_problem(1, 0);
    clear_b(); bvec[0] = -16'sd1;  run_problem(1, 0);
    clear_b();                     run_problem(10, 0);
    clear_b(); bvec[0] = 16'sd20;  run_problem(0, 0);

    rdy_mode = 1'b1;
    for (int t = 0; t < 4; t++) begin random_b(); run_problem(200, 0); end
    for (int t = 0; t < 3; t++) begin
      random_b();
      run_problem($urandom_range(1, 30), longint'($urandom_range(0, 20000)));
    end

    // Backpressure at word 3 with in_valid noise while solving.
    rdy_mode = 1'b0; manual_ready = 1'b0;
    random_b();
    push_model(12, 0);
    load_problem(12, 0);
    noise_en = 1'b1;
    wait_valid(4 * N * 12 + 50);
    pulse_words(3);
    repeat (5) begin @(posedge clk); #1; end
    manual_ready = 1'b1;
    wait_done(20 * N + 50);

    // Reset mid-SOLVE.
    random_b();
    load_problem(200, 0);
    repeat (20) begin @(posedge clk); #1; end
    do_reset();

    // Reset mid-DRAIN after two words.
    manual_ready = 1'b0;
    random_b();
    push_model(5, 0);
    load_problem(5, 0);
    wait_valid(4 * N * 5 + 50);
    pulse_words(2);
    do_reset();
    manual_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    rdy_mode = 1'b1;
    random_b();
    run_problem(200, 0);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
